// File: rtl/s2mm_pkg.sv
// Shared types and helpers for the AXI4-Stream to AXI4 memory-mapped burst writer.
// Contents: FSM state enum, AXI INCR burst encoding, 4 KB page size, and
// beat-size / awsize derivation from the data width.
package s2mm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } s2mm_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned BOUNDARY_4K    = 4096;

  // Bytes carried by one data beat.
  function automatic int unsigned beat_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // AXI awsize encoding: log2 of the beat size in bytes.
  function automatic logic [2:0] awsize_of(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/s2mm_burst_calc.sv
// Purpose: burst length = min(remaining beats, MAX_BURST_LEN, beats left in the 4 KB page).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the address and remaining-beat inputs.
// Ports: addr_lo (byte address bits [11:0], beat aligned), remaining (beats left in
//        the job), burst_len (beats for the next burst, 1..MAX_BURST_LEN when remaining>0).
module s2mm_burst_calc
  import s2mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic [11:0] addr_lo,
  input  logic [31:0] remaining,
  output logic [7:0]  burst_len
);

  localparam int unsigned SHIFT = $clog2(beat_bytes(DATA_WIDTH));

  logic [12:0] bytes_left;
  logic [31:0] page_beats;
  logic [31:0] lim;

  always_comb begin
    // Address is beat aligned, so the shift is exact (no partial beat at the page end).
    bytes_left = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    page_beats = 32'(bytes_left >> SHIFT);
    lim        = (page_beats < 32'(MAX_BURST_LEN)) ? page_beats : 32'(MAX_BURST_LEN);
    // lim never exceeds 128, so the low byte holds the whole value in either arm.
    burst_len  = (remaining < lim) ? remaining[7:0] : lim[7:0];
  end

endmodule

// File: rtl/s2mm_burst_writer.sv
// Purpose: moves total_beats AXIS beats to memory at base_addr as AXI4 INCR bursts, one burst in flight.
// Latency: AW issued one cycle after start; done pulses one cycle after the final B (or after start when total_beats=0).
// Backpressure: W beats pass straight through (wvalid=tvalid, tready=wready) only in DATA; AXIS is stalled in all other states.
// Ports: aclk/aresetn clock and async active-low reset; start/base_addr/total_beats job launch;
//        busy/done/error status; m_axi_aw*, m_axi_w*, m_axi_b* AXI4 write master; s_axis_t* stream input.
// Build option: define S2MM_BRESP_CHECK_EN to make a non-OKAY bresp set a sticky error flag
//               (cleared by the next accepted start); otherwise error is tied low and bresp ignored.
module s2mm_burst_writer
  import s2mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // job control
  input  logic                      start,
  input  logic [63:0]               base_addr,
  input  logic [31:0]               total_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  // AW channel
  output logic                      m_axi_awid,
  output logic [63:0]               m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  // W channel
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  // B channel
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  // AXIS input
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata
);

  localparam int unsigned BEAT_BYTES = beat_bytes(DATA_WIDTH);
  localparam int unsigned SHIFT      = $clog2(BEAT_BYTES);
  localparam logic [63:0] ALIGN_MASK = ~64'(BEAT_BYTES - 1);

  s2mm_state_t state;

  // datapath (no reset: only meaningful once a start has loaded them)
  logic [63:0] addr;
  logic [31:0] remaining;
  logic [7:0]  len_q;
  logic [7:0]  beat_cnt;

  // registered control outputs
  logic awvalid_q;
  logic bready_q;
  logic busy_q;
  logic done_q;

  logic [7:0] burst_len_c;
  logic       w_hs;
  logic       b_hs;
  logic       last_beat;
  logic       b_err;

  s2mm_burst_calc #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_burst_calc (
    .addr_lo   (addr[11:0]),
    .remaining (remaining),
    .burst_len (burst_len_c)
  );

  assign w_hs      = (state == DATA) && s_axis_tvalid && m_axi_wready;
  assign b_hs      = bready_q && m_axi_bvalid;
  assign last_beat = (beat_cnt == (len_q - 8'd1));

`ifdef S2MM_BRESP_CHECK_EN
  logic error_q;
  assign b_err = b_hs && (m_axi_bresp != 2'b00);
  assign error = error_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^m_axi_bresp;
  assign b_err        = 1'b0;
  assign error        = 1'b0;
`endif

  // control FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef S2MM_BRESP_CHECK_EN
      error_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
`ifdef S2MM_BRESP_CHECK_EN
            error_q <= 1'b0;
`endif
            if (total_beats == 32'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ADDR;
              awvalid_q <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs && last_beat) begin
            state    <= RESP;
            bready_q <= 1'b1;
          end
        end
        RESP: begin
          if (b_hs) begin
            bready_q <= 1'b0;
`ifdef S2MM_BRESP_CHECK_EN
            if (b_err) error_q <= 1'b1;
`endif
            // remaining still holds the pre-burst count this cycle
            if (remaining == {24'd0, len_q}) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ADDR;
              awvalid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // address / beat bookkeeping
  always_ff @(posedge aclk) begin
    case (state)
      IDLE: begin
        if (start) begin
          addr      <= base_addr & ALIGN_MASK;
          remaining <= total_beats;
        end
      end
      ADDR: begin
        if (m_axi_awready) begin
          len_q    <= burst_len_c;
          beat_cnt <= 8'd0;
        end
      end
      DATA: begin
        if (w_hs) beat_cnt <= beat_cnt + 8'd1;
      end
      RESP: begin
        if (b_hs) begin
          addr      <= addr + ({56'd0, len_q} << SHIFT);
          remaining <= remaining - {24'd0, len_q};
        end
      end
      default: ;
    endcase
  end

  // AW: addr and remaining are frozen in ADDR, so awaddr/awlen hold while awvalid waits.
  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = burst_len_c - 8'd1;
  assign m_axi_awsize  = awsize_of(DATA_WIDTH);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = awvalid_q;

  // W: gated by state so reset (state=IDLE) drops them immediately.
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state == DATA) && last_beat;
  assign m_axi_wvalid  = (state == DATA) && s_axis_tvalid;
  assign s_axis_tready = (state == DATA) && m_axi_wready;

  assign m_axi_bready  = bready_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_s2mm_burst_writer.sv
// Directed bench for s2mm_burst_writer (DATA_WIDTH=256, MAX_BURST_LEN=16).
// A cycle task plays AXI slave and AXIS source, logging AW bursts, W beats and B responses.
module tb_s2mm_burst_writer;

  localparam int DW = 256;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          start;
  logic [63:0]   base_addr;
  logic [31:0]   total_beats;
  logic          busy, done, error;
  logic          m_axi_awid;
  logic [63:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] s_axis_tdata;

  s2mm_burst_writer #(.DATA_WIDTH(DW), .MAX_BURST_LEN(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .start(start), .base_addr(base_addr), .total_beats(total_beats),
    .busy(busy), .done(done), .error(error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata)
  );

`ifdef S2MM_BRESP_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // slave / source state
  bit          stall;
  int          err_b;
  logic [7:0]  job_tag;
  int          src_idx, wr_idx, aw_hs_cnt, b_hs_cnt, done_cnt, awvalid_seen;
  logic [63:0] wlast_mask;
  logic [63:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic        err_log[8];
  bit          b_pending, aw_wait, t_hs_last;
  logic [63:0] aw_prev_addr;
  logic [7:0]  aw_prev_len;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [7:0] tag, input int i);
    logic [31:0] w;
    w = {tag, 24'(i)};
    return {8{w}};
  endfunction

  function automatic logic [63:0] aw_a(input int i);
    if (i < aw_addr_log.size()) return aw_addr_log[i];
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [7:0] aw_l(input int i);
    if (i < aw_len_log.size()) return aw_len_log[i];
    return 8'hEE;
  endfunction

  task automatic clear_logs();
    src_idx = 0; wr_idx = 0; aw_hs_cnt = 0; b_hs_cnt = 0; done_cnt = 0; awvalid_seen = 0;
    wlast_mask = '0; aw_addr_log.delete(); aw_len_log.delete();
    for (int i = 0; i < 8; i++) err_log[i] = 1'b0;
    b_pending = 0; aw_wait = 0; m_axi_bvalid = 1'b0;
  endtask

  // One clock: drive slave/source inputs after negedge, observe at negedge+1,
  // return 1 time unit after the posedge so callers can change start safely.
  task automatic cycle();
    bit aw_hs, w_hs, t_hs, b_hs;
    @(negedge aclk);
    if (!s_axis_tvalid || t_hs_last) s_axis_tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_axis_tdata  = pat(job_tag, src_idx);
    m_axi_awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
    m_axi_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    m_axi_bvalid  = b_pending && (stall ? ($urandom_range(0, 2) == 0) : 1'b1);
    m_axi_bresp   = (m_axi_bvalid && b_hs_cnt == err_b) ? 2'b10 : 2'b00;
    #1;
    if (aw_wait) begin
      check("aw_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, aw_prev_addr, aw_prev_len});
    end
    if (m_axi_awvalid) begin
      awvalid_seen++;
      check("one_outstanding", 64'(aw_hs_cnt - b_hs_cnt), 64'd0);
    end
    aw_hs = m_axi_awvalid && m_axi_awready;
    if (aw_hs) begin
      check("aw_attr", {m_axi_awid, m_axi_awburst, m_axi_awsize}, {1'b0, 2'b01, 3'd5});
      aw_addr_log.push_back(m_axi_awaddr);
      aw_len_log.push_back(m_axi_awlen);
      aw_hs_cnt++;
    end
    aw_wait = m_axi_awvalid && !m_axi_awready;
    aw_prev_addr = m_axi_awaddr;
    aw_prev_len  = m_axi_awlen;
    w_hs = m_axi_wvalid && m_axi_wready;
    t_hs = s_axis_tvalid && s_axis_tready;
    if (w_hs || t_hs) check("axis_eq_w", 64'(w_hs), 64'(t_hs));
    if (w_hs) begin
      check("wdata", m_axi_wdata[63:0], pat(job_tag, wr_idx)[63:0]);
      if (m_axi_wlast) begin
        if (wr_idx < 64) wlast_mask[wr_idx] = 1'b1;
        b_pending = 1;
      end
      wr_idx++;
    end
    if (t_hs) src_idx++;
    t_hs_last = t_hs;
    b_hs = m_axi_bvalid && m_axi_bready;
    if (b_hs) begin
      b_pending = 0;
      b_hs_cnt++;
    end
    if (done) done_cnt++;
    @(posedge aclk);
    #1;
    if (b_hs && b_hs_cnt <= 8) err_log[b_hs_cnt-1] = error;
  endtask

  task automatic run_job(input logic [63:0] base, input int total, input bit stl,
                         input int errb, input logic [7:0] tag, input bit inject, input int budget);
    clear_logs();
    stall = stl; err_b = errb; job_tag = tag;
    base_addr = base; total_beats = 32'(total); start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 0; n < budget && done_cnt == 0; n++) begin
      if (inject && n == 10) begin
        start = 1'b1; base_addr = 64'hDEAD_0000; total_beats = 32'd5;
      end
      cycle();
      start = 1'b0;
    end
    check("job_finished_in_budget", 64'(done_cnt != 0), 64'd1);
    repeat (4) cycle();
    check("done_once", 64'(done_cnt), 64'd1);
    check("idle_after_job", 64'(busy), 64'd0);
    check("beats_written", 64'(wr_idx), 64'(total));
  endtask

  initial begin
    start = 0; base_addr = '0; total_beats = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    s_axis_tvalid = 0; s_axis_tdata = '0; t_hs_last = 0;
    stall = 0; err_b = -1; job_tag = 8'h00;
    clear_logs();

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst_wlast", 64'(m_axi_wlast), 64'd0);
    check("rst_bready", 64'(m_axi_bready), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // 40 beats at 0x1000, with a start pulse mid-job that must be ignored
    run_job(64'h1000, 40, 0, -1, 8'h0A, 1, 600);
    check("A_aw_count", 64'(aw_hs_cnt), 64'd3);
    check("A_aw0", {aw_a(0), aw_l(0)}, {64'h1000, 8'd15});
    check("A_aw1", {aw_a(1), aw_l(1)}, {64'h1200, 8'd15});
    check("A_aw2", {aw_a(2), aw_l(2)}, {64'h1400, 8'd7});
    check("A_wlast", wlast_mask, 64'h0000_0080_8000_8000);
    check("A_wstrb", 64'(m_axi_wstrb), 64'hFFFF_FFFF);

    // 4 KB boundary split
    run_job(64'h0FC0, 8, 0, -1, 8'h0B, 0, 300);
    check("B_aw_count", 64'(aw_hs_cnt), 64'd2);
    check("B_aw0", {aw_a(0), aw_l(0)}, {64'h0FC0, 8'd1});
    check("B_aw1", {aw_a(1), aw_l(1)}, {64'h1000, 8'd5});
    check("B_wlast", wlast_mask, 64'h82);

    // unaligned base is forced down to a 32-byte boundary
    run_job(64'h2013, 3, 0, -1, 8'h0C, 0, 300);
    check("C_aw0", {aw_a(0), aw_l(0)}, {64'h2000, 8'd2});
    check("C_wlast", wlast_mask, 64'h4);

    // zero-length job
    clear_logs();
    base_addr = 64'h8000; total_beats = 32'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("Z_busy_hi", 64'(busy), 64'd1);
    check("Z_done_hi", 64'(done), 64'd1);
    cycle();
    check("Z_busy_lo", 64'(busy), 64'd0);
    check("Z_done_lo", 64'(done), 64'd0);
    repeat (3) cycle();
    check("Z_no_awvalid", 64'(awvalid_seen), 64'd0);
    check("Z_done_once", 64'(done_cnt), 64'd1);

    // random stalls on every channel
    run_job(64'h3000, 33, 1, -1, 8'h0D, 0, 3000);
    check("D_aw_count", 64'(aw_hs_cnt), 64'd3);
    check("D_aw0", {aw_a(0), aw_l(0)}, {64'h3000, 8'd15});
    check("D_aw1", {aw_a(1), aw_l(1)}, {64'h3200, 8'd15});
    check("D_aw2", {aw_a(2), aw_l(2)}, {64'h3400, 8'd0});
    check("D_wlast", wlast_mask, 64'h1_8000_8000);

    // SLVERR on the second of three bursts
    run_job(64'h5000, 40, 0, 1, 8'h0E, 0, 600);
    check("E_err_after_b0", 64'(err_log[0]), 64'd0);
    check("E_err_after_b1", 64'(err_log[1]), 64'(ERR_EXP));
    check("E_err_after_b2", 64'(err_log[2]), 64'(ERR_EXP));
    check("E_err_at_end", 64'(error), 64'(ERR_EXP));

    // reset in the middle of a burst, after 5 beats
    clear_logs();
    stall = 0; err_b = -1; job_tag = 8'h0F;
    base_addr = 64'h6000; total_beats = 32'd20; start = 1'b1;
    cycle();
    start = 1'b0;
    check("F_err_cleared_by_start", 64'(error), 64'd0);
    for (int n = 0; n < 200 && wr_idx < 5; n++) cycle();
    check("F_five_beats", 64'(wr_idx), 64'd5);
    aresetn = 1'b0;
    #1;
    check("F_rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("F_rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("F_rst_wlast", 64'(m_axi_wlast), 64'd0);
    check("F_rst_bready", 64'(m_axi_bready), 64'd0);
    check("F_rst_tready", 64'(s_axis_tready), 64'd0);
    check("F_rst_busy", 64'(busy), 64'd0);
    check("F_rst_done", 64'(done), 64'd0);
    repeat (2) cycle();
    aresetn = 1'b1;
    cycle();

    run_job(64'h7000, 20, 0, -1, 8'h1F, 0, 600);
    check("G_aw_count", 64'(aw_hs_cnt), 64'd2);
    check("G_aw0", {aw_a(0), aw_l(0)}, {64'h7000, 8'd15});
    check("G_aw1", {aw_a(1), aw_l(1)}, {64'h7200, 8'd3});
    check("G_wlast", wlast_mask, 64'h8_8000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
